// File: rtl/bp_cce_lce_req_receiver.sv
// bp_cce_lce_req_receiver
// CCE-side sink for the LCE request channel. Accepts a request header (and the
// single data beat of an uncached store), holds it as one registered request for
// the CCE core on a valid/yumi handshake, and limits in-flight requests with a
// credit counter.
// Optional feature: define BP_CCE_LCE_REQ_RECEIVER_CHECK_EN to build the sticky
// protocol checker behind error_o; otherwise error_o is tied to 0.
// Header layout: [3:0] msg_type.req, [6:4] msg size, [HDR_W-1:7] address.
module bp_cce_lce_req_receiver #(
    parameter int HDR_W     = 64,
    parameter int DATA_W    = 64,
    parameter int credits_p = 2,
    localparam int CNT_W    = $clog2(credits_p + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [HDR_W-1:0]  lce_req_header_i,
    input  logic              lce_req_header_v_i,
    output logic              lce_req_header_ready_and_o,
    input  logic [DATA_W-1:0] lce_req_data_i,
    input  logic              lce_req_data_v_i,
    output logic              lce_req_data_ready_and_o,
    input  logic              lce_req_last_i,
    output logic [HDR_W-1:0]  req_header_o,
    output logic [DATA_W-1:0] req_data_o,
    output logic              req_v_o,
    input  logic              req_yumi_i,
    input  logic              req_complete_i,
    output logic [CNT_W-1:0]  credit_count_o,
    output logic              error_o
);

    localparam logic [3:0] REQ_UC_WR   = 4'd3;
    localparam logic [2:0] MSG_SIZE_8  = 3'd3;

    typedef enum logic [1:0] {
        e_reset     = 2'd0,
        e_ready     = 2'd1,
        e_wait_data = 2'd2,
        e_pending   = 2'd3
    } state_e;

    state_e            state_r, state_n;
    logic [HDR_W-1:0]  header_r;
    logic [DATA_W-1:0] data_r;
    logic [CNT_W-1:0]  count_r;

    logic              hdr_cap, data_cap, data_clr;
    logic              credit_ok, is_uc_wr;
    logic [2:0]        hdr_size;

    assign is_uc_wr  = (lce_req_header_i[3:0] == REQ_UC_WR);
    assign hdr_size  = lce_req_header_i[6:4];
    assign credit_ok = (count_r < CNT_W'(credits_p));

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_reset;
        else         state_r <= state_n;
    end

    // Next-state, handshake readies and capture strobes
    always_comb begin
        state_n                    = state_r;
        lce_req_header_ready_and_o = 1'b0;
        lce_req_data_ready_and_o   = 1'b0;
        req_v_o                    = 1'b0;
        hdr_cap                    = 1'b0;
        data_cap                   = 1'b0;
        data_clr                   = 1'b0;
        case (state_r)
            e_reset: state_n = e_ready;
            e_ready: begin
                lce_req_header_ready_and_o = credit_ok;
                if (credit_ok && lce_req_header_v_i) begin
                    hdr_cap = 1'b1;
                    if (is_uc_wr) begin
                        lce_req_data_ready_and_o = 1'b1;
                        if (lce_req_data_v_i) begin
                            data_cap = 1'b1;
                            state_n  = e_pending;
                        end else begin
                            state_n  = e_wait_data;
                        end
                    end else begin
                        data_clr = 1'b1;
                        state_n  = e_pending;
                    end
                end
            end
            e_wait_data: begin
                lce_req_data_ready_and_o = 1'b1;
                if (lce_req_data_v_i) begin
                    data_cap = 1'b1;
                    state_n  = e_pending;
                end
            end
            e_pending: begin
                req_v_o = 1'b1;
                if (req_yumi_i) state_n = e_ready;
            end
            default: state_n = e_reset;
        endcase
    end

    // Request holding registers; they only move on a capture
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            header_r <= '0;
            data_r   <= '0;
        end else begin
            if (hdr_cap)  header_r <= lce_req_header_i;
            if (data_cap) data_r   <= lce_req_data_i;
            else if (data_clr) data_r <= '0;
        end
    end

    // Outstanding-request counter; a complete with nothing outstanding is ignored
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else begin
            case ({req_yumi_i, req_complete_i})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   if (count_r != '0) count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign req_header_o   = header_r;
    assign req_data_o     = data_r;
    assign credit_count_o = count_r;

`ifdef BP_CCE_LCE_REQ_RECEIVER_CHECK_EN
    logic chk_fail, error_r;

    assign chk_fail = (hdr_cap && is_uc_wr && (hdr_size > MSG_SIZE_8))
                   || (hdr_cap && !is_uc_wr && !lce_req_last_i)
                   || (data_cap && !lce_req_last_i)
                   || (req_complete_i && !req_yumi_i && (count_r == '0));

    // Sticky protocol error flag, cleared only by reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)       error_r <= 1'b0;
        else if (chk_fail) error_r <= 1'b1;
    end

    assign error_o = error_r;
`else
    logic unused_chk_inputs;
    assign unused_chk_inputs = ^{lce_req_last_i, hdr_size, MSG_SIZE_8};
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cce_lce_req_receiver.sv
// Directed testbench for bp_cce_lce_req_receiver (credits_p = 2).
module tb_bp_cce_lce_req_receiver;

    localparam int HDR_W  = 64;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [HDR_W-1:0]  hdr_i = '0;
    logic              hdr_v = 1'b0;
    logic              hdr_rdy;
    logic [DATA_W-1:0] dat_i = '0;
    logic              dat_v = 1'b0;
    logic              dat_rdy;
    logic              last = 1'b0;
    logic [HDR_W-1:0]  req_hdr;
    logic [DATA_W-1:0] req_dat;
    logic              req_v;
    logic              yumi = 1'b0;
    logic              cmpl = 1'b0;
    logic [CNT_W-1:0]  cnt;
    logic              err;

    int errors = 0;
    int checks = 0;

    bp_cce_lce_req_receiver #(.HDR_W(HDR_W), .DATA_W(DATA_W), .credits_p(2)) dut (
        .clk_i                      (clk),
        .reset_i                    (rst),
        .lce_req_header_i           (hdr_i),
        .lce_req_header_v_i         (hdr_v),
        .lce_req_header_ready_and_o (hdr_rdy),
        .lce_req_data_i             (dat_i),
        .lce_req_data_v_i           (dat_v),
        .lce_req_data_ready_and_o   (dat_rdy),
        .lce_req_last_i             (last),
        .req_header_o               (req_hdr),
        .req_data_o                 (req_dat),
        .req_v_o                    (req_v),
        .req_yumi_i                 (yumi),
        .req_complete_i             (cmpl),
        .credit_count_o             (cnt),
        .error_o                    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [HDR_W-1:0] mk_hdr(input logic [3:0] typ, input logic [2:0] size,
                                                input logic [56:0] addr);
        return {addr, size, typ};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge (input drive point)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // move to the falling edge to sample outputs
    task automatic smp();
        @(negedge clk);
    endtask

    localparam logic [3:0] RD_MISS = 4'd0;
    localparam logic [3:0] UC_WR   = 4'd3;

    logic [HDR_W-1:0] h1, h2, h3, h4, h5, h6, h7;

    initial begin
        h1 = mk_hdr(RD_MISS, 3'd3, 57'h8000_0040);
        h2 = mk_hdr(UC_WR,   3'd3, 57'h0000_1000);
        h3 = mk_hdr(UC_WR,   3'd3, 57'h0000_2000);
        h4 = mk_hdr(RD_MISS, 3'd3, 57'h0000_3000);
        h5 = mk_hdr(RD_MISS, 3'd3, 57'h0000_4000);
        h6 = mk_hdr(UC_WR,   3'd4, 57'h0000_5000);
        h7 = mk_hdr(UC_WR,   3'd3, 57'h0000_6000);

        // ---- reset state ----
        #2 rst = 1'b1;
        #1;
        chk("rst_req_v", req_v, 0);
        chk("rst_hdr_rdy", hdr_rdy, 0);
        chk("rst_dat_rdy", dat_rdy, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_hdr", req_hdr, 0);
        chk("rst_dat", req_dat, 0);
        step();
        rst = 1'b0;
        smp();
        chk("e_reset_hdr_rdy", hdr_rdy, 0);
        step();
        smp();
        chk("ready_hdr_rdy", hdr_rdy, 1);

        // ---- cached read miss ----
        step();
        hdr_i = h1; hdr_v = 1'b1; last = 1'b1;
        smp();
        chk("rd_hdr_rdy", hdr_rdy, 1);
        chk("rd_dat_rdy", dat_rdy, 0);
        chk("rd_v_before", req_v, 0);
        step();
        hdr_v = 1'b0;
        smp();
        chk("rd_v", req_v, 1);
        chk("rd_hdr", req_hdr, h1);
        chk("rd_dat_zero", req_dat, 0);
        chk("rd_pend_hdr_rdy", hdr_rdy, 0);
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        smp();
        chk("rd_v_after_yumi", req_v, 0);
        chk("rd_cnt", cnt, 1);
        cmpl = 1'b1;
        step();
        cmpl = 1'b0;
        smp();
        chk("rd_cnt_ret", cnt, 0);

        // ---- uc_wr header and data same cycle ----
        step();
        hdr_i = h2; hdr_v = 1'b1; dat_i = 64'hDEAD_BEEF_0000_0001; dat_v = 1'b1; last = 1'b1;
        smp();
        chk("ucw_dat_rdy", dat_rdy, 1);
        step();
        hdr_v = 1'b0; dat_v = 1'b0;
        smp();
        chk("ucw_v", req_v, 1);
        chk("ucw_dat", req_dat, 64'hDEAD_BEEF_0000_0001);
        chk("ucw_hdr", req_hdr, h2);
        yumi = 1'b1;
        step();
        yumi = 1'b0; cmpl = 1'b1;
        step();
        cmpl = 1'b0;
        smp();
        chk("ucw_cnt", cnt, 0);

        // ---- uc_wr, data three cycles late ----
        step();
        hdr_i = h3; hdr_v = 1'b1; last = 1'b0;
        smp();
        chk("late_dat_rdy0", dat_rdy, 1);
        step();
        hdr_v = 1'b0;
        smp();
        chk("late_hdr_rdy", hdr_rdy, 0);
        chk("late_dat_rdy1", dat_rdy, 1);
        chk("late_v1", req_v, 0);
        step();
        smp();
        chk("late_dat_rdy2", dat_rdy, 1);
        chk("late_v2", req_v, 0);
        step();
        dat_i = 64'h1234_5678_9ABC_DEF0; dat_v = 1'b1; last = 1'b1;
        smp();
        chk("late_v3", req_v, 0);
        step();
        dat_v = 1'b0;
        smp();
        chk("late_v", req_v, 1);
        chk("late_dat", req_dat, 64'h1234_5678_9ABC_DEF0);
        chk("late_hdr", req_hdr, h3);
        yumi = 1'b1;
        step();
        yumi = 1'b0;

        // ---- credit limit (credits_p = 2) ----
        hdr_i = h4; hdr_v = 1'b1;
        step();
        hdr_v = 1'b0; yumi = 1'b1;
        step();
        yumi = 1'b0;
        hdr_i = h5; hdr_v = 1'b1;
        smp();
        chk("cred_cnt2", cnt, 2);
        chk("cred_hdr_rdy0", hdr_rdy, 0);
        step();
        cmpl = 1'b1;
        smp();
        chk("cred_blocked_v", req_v, 0);
        chk("cred_hdr_rdy_same", hdr_rdy, 0);
        step();
        cmpl = 1'b0;
        smp();
        chk("cred_cnt1", cnt, 1);
        chk("cred_hdr_rdy1", hdr_rdy, 1);
        step();
        hdr_v = 1'b0;
        smp();
        chk("cred_v", req_v, 1);
        chk("cred_hdr", req_hdr, h5);

        // ---- simultaneous yumi and complete at count 1 ----
        yumi = 1'b1; cmpl = 1'b1;
        step();
        yumi = 1'b0; cmpl = 1'b0;
        smp();
        chk("simul_cnt", cnt, 1);
        chk("simul_v", req_v, 0);

        // ---- oversize uc_wr ----
        step();
        hdr_i = h6; hdr_v = 1'b1; dat_i = 64'h55; dat_v = 1'b1; last = 1'b1;
        step();
        hdr_v = 1'b0; dat_v = 1'b0;
        smp();
        chk("big_v", req_v, 1);
`ifdef BP_CCE_LCE_REQ_RECEIVER_CHECK_EN
        chk("big_err", err, 1);
`else
        chk("big_err", err, 0);
`endif
        yumi = 1'b1;
        step();
        yumi = 1'b0; cmpl = 1'b1;
        step();
        cmpl = 1'b0;
        smp();
        chk("big_cnt", cnt, 1);
`ifdef BP_CCE_LCE_REQ_RECEIVER_CHECK_EN
        chk("big_err_sticky", err, 1);
`else
        chk("big_err_sticky", err, 0);
`endif

        // ---- async reset during e_wait_data ----
        step();
        hdr_i = h7; hdr_v = 1'b1; last = 1'b0;
        step();
        hdr_v = 1'b0;
        smp();
        chk("ar_wait_dat_rdy", dat_rdy, 1);
        chk("ar_hdr_cap", req_hdr, h7);
        #2 rst = 1'b1;
        #1;
        chk("ar_req_v", req_v, 0);
        chk("ar_hdr_rdy", hdr_rdy, 0);
        chk("ar_dat_rdy", dat_rdy, 0);
        chk("ar_cnt", cnt, 0);
        chk("ar_err", err, 0);
        chk("ar_hdr", req_hdr, 0);
        chk("ar_dat", req_dat, 0);
        step();
        rst = 1'b0;
        step();
        smp();
        chk("ar_recover_hdr_rdy", hdr_rdy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_cce_lce_req_receiver.md
# bp_cce_lce_req_receiver

CCE-side sink for the LCE request channel of the BedRock burst interface. Accepts LCE request headers, plus the single data beat of uncached stores, over independent valid/ready_and channels. Merges them into one registered request presented to the CCE core on a valid/yumi handshake. Tracks outstanding requests against a credit limit so the CCE never holds more in-flight requests than it can complete.

## Interface
- bp_params_p, e_bp_default_cfg — processor parameter set; supplies widths via `declare_bp_proc_params` and `declare_bp_bedrock_lce_if_widths`.
- credits_p, coh_noc_max_credits_p — maximum requests delivered to the CCE and not yet completed.

Ports, clock and reset first:
- clk_i  in  1  — sole clock.
- reset_i  in  1  — reset; asynchronous, active-high.
- lce_req_header_i  in  lce_req_msg_header_width_lp  — incoming request header.
- lce_req_header_v_i  in  1  — header valid.
- lce_req_header_ready_and_o  out  1  — header ready.
- lce_req_data_i  in  dword_width_gp  — uncached store data beat.
- lce_req_data_v_i  in  1  — data valid.
- lce_req_data_ready_and_o  out  1  — data ready.
- lce_req_last_i  in  1  — last beat of message; used only by the checker.
- req_header_o  out  lce_req_msg_header_width_lp  — registered header to CCE.
- req_data_o  out  dword_width_gp  — registered data; zero for non-uc_wr requests.
- req_v_o  out  1  — request valid to CCE.
- req_yumi_i  in  1  — CCE consumes request; legal only while req_v_o=1.
- req_complete_i  in  1  — one-cycle pulse per finished request; returns one credit.
- credit_count_o  out  `BSG_WIDTH(credits_p)  — outstanding count.
- error_o  out  1  — sticky protocol error; see Configuration.

## Operation
- State machine e_reset → e_ready → {e_wait_data, e_pending}.
- **e_reset:** one cycle after reset deasserts, then e_ready. All ready/valid outputs are 0.
- **e_ready:** lce_req_header_ready_and_o = (credit_count_o < credits_p).
  - Header handshake captures the header into header_r.
  - If msg_type.req == e_bedrock_req_uc_wr:
    - lce_req_data_ready_and_o is also 1 this cycle.
    - If data handshakes in the same cycle, capture it into data_r and go to e_pending.
    - Otherwise go to e_wait_data.
  - Any other type: data_r ← 0, go to e_pending.
  - A data beat arriving in e_ready without a uc_wr header is not accepted (ready_and=0).
- **e_wait_data:** header ready 0, data ready 1. Data handshake captures data_r and goes to e_pending.
- **e_pending:** req_v_o=1, both ready outputs 0. req_yumi_i returns to e_ready.
- **Credit counter:**
  - +1 on req_yumi_i; −1 on req_complete_i.
  - Both in the same cycle → unchanged.
  - Saturation is impossible by construction. A complete at count 0 is a protocol error: the counter holds at 0.
- Output regs: req_header_o=header_r, req_data_o=data_r. They change only on capture.

## Timing
- Reset values: state e_reset; req_v_o=0; both ready outputs=0; credit_count_o=0; error_o=0; header_r=data_r=0.
- Asynchronous reset mid-operation discards any captured request immediately. Credits clear to 0.
- Minimum latency, header (and same-cycle data) accept → req_v_o: 1 cycle.
- Throughput: one request per 2 cycles (accept, yumi), since e_pending blocks new headers.
- Ready outputs are functions of state and registered count, plus the header_v_i/msg_type decode for data ready in e_ready. No ready depends on req_yumi_i.
- A credit returned in cycle N is visible to header ready in cycle N+1.

## Configuration
- `BP_CCE_LCE_REQ_RECEIVER_CHECK_EN`
  - **Defined:** the receiver checks each message for protocol errors:
    - uc_wr header size > e_bedrock_msg_size_8;
    - lce_req_last_i=0 on a header-only message or on the uc_wr data beat;
    - req_complete_i at count 0.
  - On any check failure, error_o sets and stays set until reset. The request is still delivered.
  - **Undefined:** error_o is tied to 0 and no check logic is built.

## Test plan
- **Cached read miss:** e_bedrock_req_rd_miss header, addr 0x8000_0040, last=1 → req_v_o next cycle; req_data_o=0; after yumi, credit_count_o=1.
- **uc_wr, header and data same cycle:** data 0xDEAD_BEEF_0000_0001 → req_v_o one cycle later with that data.
- **uc_wr, data 3 cycles late:** → header ready drops after accept, data ready stays 1, req_v_o appears the cycle after the data handshake.
- **credits_p=2:**
  - Two requests yumied with no completes → header ready=0 while a third header waits.
  - A req_complete_i pulse → third header accepted the following cycle.
- **Simultaneous yumi and complete at count 1:** → count stays 1.
- **Checker:** with `BP_CCE_LCE_REQ_RECEIVER_CHECK_EN`, uc_wr with size e_bedrock_msg_size_16 → error_o=1 and stays 1. Async reset asserted mid-e_wait_data → all outputs at reset values immediately.
